// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and defaults for the SPI controller/peripheral pair
package spi_pkg;
    localparam int DEFAULT_TRANSACTION_LENGTH_BITS = 8;
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        HOLD  = 3'b100
    } spi_state_e;
endpackage

// File: rtl/spi_input_synchronizer.sv
// spi_input_synchronizer: 2-FF synchronizer with registered previous value and edge pulses
module spi_input_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RESET_VALUE}};
            prev_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[0], in_i};
            prev_q <= sync_q[1];
        end
    end
    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 responder with valid/ready TX preload and valid-only RX stream
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int TRANSACTION_LENGTH_BITS = DEFAULT_TRANSACTION_LENGTH_BITS,
    parameter logic [TRANSACTION_LENGTH_BITS-1:0] IDLE_WORD = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               axiiv,
    input  logic [TRANSACTION_LENGTH_BITS-1:0] axiid,
    output logic                               axiready,
    output logic                               axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
    output logic                               frame_error,
    input  logic                               spi_cs_n,
    input  logic                               spi_clk,
    input  logic                               spi_din,
    output logic                               spi_dout
);
    localparam int N  = TRANSACTION_LENGTH_BITS;
    localparam int M  = N - 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic cs_n_s, cs_rise, cs_fall;
    logic sclk_rise, sclk_fall, din_s;
    logic unused_sclk_level, unused_din_rise, unused_din_fall;

    spi_state_e    state_q;
    logic [1:0]    prime_q;
    logic          armed_q, hold_valid_q, axiov_q, frame_error_q, dout_q;
    logic [N-1:0]  hold_q, axiod_q, tx_load_d;
    logic [M-1:0]  tx_q, rx_q, rx_d;
    logic [CW-1:0] cnt_q;
    logic          start_d;

    spi_input_synchronizer #(.RESET_VALUE(1'b1)) u_cs (
        .clk(clk), .rst(rst), .in_i(spi_cs_n),
        .level_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_input_synchronizer #(.RESET_VALUE(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .in_i(spi_clk),
        .level_o(unused_sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_input_synchronizer #(.RESET_VALUE(1'b0)) u_din (
        .clk(clk), .rst(rst), .in_i(spi_din),
        .level_o(din_s), .rise_o(unused_din_rise), .fall_o(unused_din_fall)
    );

    // prime_q keeps the reset value of the CS synchronizer from arming a frame while CS is held low
    assign start_d   = (state_q == IDLE) && cs_fall && armed_q;
    assign tx_load_d = hold_valid_q ? hold_q : IDLE_WORD;
    assign rx_d      = M'({rx_q, din_s});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prime_q       <= '0;
            armed_q       <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_q        <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            cnt_q         <= '0;
            axiov_q       <= 1'b0;
            axiod_q       <= '0;
            frame_error_q <= 1'b0;
            dout_q        <= 1'b0;
        end else begin
            axiov_q       <= 1'b0;
            frame_error_q <= 1'b0;
            prime_q       <= {prime_q[0], 1'b1};
            if (cs_n_s && prime_q[1]) armed_q <= 1'b1;
            else if (start_d) armed_q <= 1'b0;
            if (axiiv && !hold_valid_q) begin
                hold_q       <= axiid;
                hold_valid_q <= 1'b1;
            end else if (start_d) begin
                hold_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (start_d) begin
                    tx_q    <= tx_load_d[M-1:0];
                    dout_q  <= tx_load_d[N-1];
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_q  <= rx_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (sclk_rise && cnt_q == LAST) begin
                        axiod_q <= {rx_q, din_s};
                        axiov_q <= 1'b1;
                        state_q <= cs_rise ? IDLE : HOLD;
                        dout_q  <= cs_rise ? 1'b0 : dout_q;
                    end else if (cs_rise) begin
                        frame_error_q <= 1'b1;
                        dout_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else if (sclk_fall && cnt_q != '0) begin
                        dout_q <= tx_q[M-1];
                        tx_q   <= tx_q << 1;
                    end
                end
                HOLD: if (cs_rise) begin
                    dout_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axiready    = ~hold_valid_q;
    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign frame_error = frame_error_q;
    assign spi_dout    = dout_q;
endmodule
